// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the writeback stage, the destination
// selector and, later, the hazard unit.
//   - icode constants I_HALT..I_POPQ
//   - register index constants REG_NONE and REG_RSP
//   - processor status encoding stat_t
//   - is_commit_icode(): true for the codes that retire normally (1..B)
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [1:0] {
        STAT_RUN  = 2'd0,
        STAT_HALT = 2'd1,
        STAT_ERR  = 2'd2
    } stat_t;

    function automatic logic is_commit_icode(input logic [3:0] code);
        return (code != I_HALT) && (code <= I_POPQ);
    endfunction

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational destination selector: maps a retiring instruction to the
// register indices written from valE (dst_e) and valM (dst_m).
// REG_NONE means "no write".
//   icode, rA, rB : instruction fields
//   cnd           : condition result, gates cmovXX
//   dstE, dstM    : selected destinations
module wb_dst_sel
    import y86_pkg::*;
#(
    parameter logic [3:0] RSP_IDX = REG_RSP
) (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

    always_comb begin
        dstE = REG_NONE;
        case (icode)
            I_RRMOVQ:                      dstE = cnd ? rB : REG_NONE;
            I_IRMOVQ, I_OPQ:               dstE = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: dstE = RSP_IDX;
            default:                       dstE = REG_NONE;
        endcase
    end

    always_comb begin
        dstM = REG_NONE;
        case (icode)
            I_MRMOVQ, I_POPQ: dstM = rA;
            default:          dstM = REG_NONE;
        endcase
    end

endmodule

// File: rtl/main_writeback.sv
// Write-back stage and register-file owner of the sequential Y86-64 core.
//   clk, rst_n            : clock, async active-low reset
//   wb_valid, icode, rA,
//   rB, cnd, valE, valM   : retiring instruction and its results
//   srcA, srcB / rdA, rdB : two combinational decode read ports (F reads 0)
//   stat                  : RUN / HALT / ERR, sticky until reset
//   retired               : committed-instruction counter, wraps silently
module main_writeback
    import y86_pkg::*;
#(
    parameter int unsigned NREG    = 15,
    parameter int unsigned WIDTH   = 64,
    parameter logic [3:0]  RSP_IDX = REG_RSP,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] rdA,
    output logic [WIDTH-1:0] rdB,
    output logic [1:0]       stat,
    output logic [CNT_W-1:0] retired
);

    logic [WIDTH-1:0] regs [NREG];
    stat_t            stat_q;
    logic [CNT_W-1:0] retired_q;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;

    wb_dst_sel #(.RSP_IDX(RSP_IDX)) u_dst_sel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dstE  (dst_e),
        .dstM  (dst_m)
    );

    // No bypass: a register written this cycle still reads its old value.
    assign rdA     = (srcA == REG_NONE) ? '0 : regs[srcA];
    assign rdB     = (srcB == REG_NONE) ? '0 : regs[srcB];
    assign stat    = stat_q;
    assign retired = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            stat_q    <= STAT_RUN;
            retired_q <= '0;
        end else if (wb_valid && stat_q == STAT_RUN) begin
            if (icode == I_HALT) begin
                stat_q <= STAT_HALT;
            end else if (!is_commit_icode(icode)) begin
                stat_q <= STAT_ERR;
            end else begin
                if (dst_e != REG_NONE) regs[dst_e] <= valE;
                // Placed after the valE write so popq %rsp keeps valM.
                if (dst_m != REG_NONE) regs[dst_m] <= valM;
                retired_q <= retired_q + 1'b1;
            end
        end
    end

endmodule
